// File: rtl/ysyx_041461_mem_lsu_pkg.sv
// rtl/ysyx_041461_mem_lsu_pkg.sv - shared op codes, exception codes and FSM states for the MEM-stage LSU
//
// Purpose: single home for the memory op encoding, the exception codes
// reported by the MEM stage, and the LSU state type.
// Ports: none (package).
package ysyx_041461_mem_lsu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LH  = 4'd2,
    OP_LW  = 4'd3,
    OP_LD  = 4'd4,
    OP_LBU = 4'd5,
    OP_LHU = 4'd6,
    OP_LWU = 4'd7,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10,
    OP_SD  = 4'd11
  } mem_op_e;

  localparam logic [2:0] ysyx_041461_exception_NOP = 3'd0;
  localparam logic [2:0] ysyx_041461_exception_LAM = 3'd1;  // load address misaligned
  localparam logic [2:0] ysyx_041461_exception_SAM = 3'd2;  // store address misaligned

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/ysyx_041461_mem_lsu_if.sv
// rtl/ysyx_041461_mem_lsu_if.sv - data memory bus between the LSU and memory
//
// Purpose: groups the request/ack bus so it can be passed as one port.
// Signals: mem_req, mem_wen, mem_addr[63:0], mem_wdata[63:0] (lane-aligned),
//          mem_wmask[7:0] (byte enables) from master; mem_ack (one-cycle
//          completion), mem_rdata[63:0] (lane-aligned, valid with ack) from slave.
interface ysyx_041461_mem_lsu_if;
  logic        mem_req;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ysyx_041461_mem_lsu_align.sv
// rtl/ysyx_041461_mem_lsu_align.sv - combinational lane shift, byte mask and load extension
//
// Purpose: converts between right-aligned register data and lane-aligned bus
// data for one memory op, and reports the op's kind and alignment.
// Ports: ctrl_i (op code), addr_lo_i (address bits [2:0]), wdata_i (store data,
//        right-aligned), rdata_i (bus read data, lane-aligned);
//        wdata_lane_o, wmask_o, rdata_ext_o, aligned_o, is_load_o, is_store_o.
module ysyx_041461_MEM_align
  import ysyx_041461_mem_lsu_pkg::*;
(
  input  logic [3:0]  ctrl_i,
  input  logic [2:0]  addr_lo_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [63:0] wdata_lane_o,
  output logic [7:0]  wmask_o,
  output logic [63:0] rdata_ext_o,
  output logic        aligned_o,
  output logic        is_load_o,
  output logic        is_store_o
);
  logic [5:0]  shamt;
  logic [63:0] rsh;
  logic [7:0]  base_mask;

  assign shamt        = {addr_lo_i, 3'b000};
  assign rsh          = rdata_i >> shamt;
  assign wdata_lane_o = wdata_i << shamt;
  assign wmask_o      = base_mask << addr_lo_i;
  assign is_load_o    = ctrl_i inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  assign is_store_o   = ctrl_i inside {OP_SB, OP_SH, OP_SW, OP_SD};

  always_comb begin
    base_mask   = 8'h00;
    aligned_o   = 1'b1;
    rdata_ext_o = 64'd0;
    case (ctrl_i)
      OP_LB:         begin base_mask = 8'h01; rdata_ext_o = {{56{rsh[7]}}, rsh[7:0]}; end
      OP_LBU, OP_SB: begin base_mask = 8'h01; rdata_ext_o = {56'd0, rsh[7:0]}; end
      OP_LH:         begin base_mask = 8'h03; aligned_o = ~addr_lo_i[0];
                           rdata_ext_o = {{48{rsh[15]}}, rsh[15:0]}; end
      OP_LHU, OP_SH: begin base_mask = 8'h03; aligned_o = ~addr_lo_i[0];
                           rdata_ext_o = {48'd0, rsh[15:0]}; end
      OP_LW:         begin base_mask = 8'h0F; aligned_o = (addr_lo_i[1:0] == 2'b00);
                           rdata_ext_o = {{32{rsh[31]}}, rsh[31:0]}; end
      OP_LWU, OP_SW: begin base_mask = 8'h0F; aligned_o = (addr_lo_i[1:0] == 2'b00);
                           rdata_ext_o = {32'd0, rsh[31:0]}; end
      OP_LD, OP_SD:  begin base_mask = 8'hFF; aligned_o = (addr_lo_i == 3'b000);
                           rdata_ext_o = rsh; end
      default:       ;
    endcase
  end
endmodule

// File: rtl/ysyx_041461_mem_lsu.sv
// rtl/ysyx_041461_mem_lsu.sv - MEM-stage load/store unit driving a single-outstanding memory bus
//
// Purpose: accepts one memory op from the MEM stage, runs at most one bus
// transaction for it, and hands the (extended) result to the WB register.
// Ports: clk, rst (async, active-high); MEM_valid_in, MEM_ctrl_in[3:0],
//        MEM_addr_in[63:0], MEM_wdata_in[63:0], MEM_flush, WBreg_enable;
//        MEM_valid_out, MEM_rdata_out[63:0], MEM_exception_out[2:0],
//        MEM_stall_out; bus (memory bus, master side).
module ysyx_041461_mem_lsu
  import ysyx_041461_mem_lsu_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          MEM_valid_in,
  input  logic [3:0]                    MEM_ctrl_in,
  input  logic [63:0]                   MEM_addr_in,
  input  logic [63:0]                   MEM_wdata_in,
  input  logic                          MEM_flush,
  input  logic                          WBreg_enable,
  output logic                          MEM_valid_out,
  output logic [63:0]                   MEM_rdata_out,
  output logic [2:0]                    MEM_exception_out,
  output logic                          MEM_stall_out,
  ysyx_041461_mem_lsu_if.master         bus
);
  lsu_state_e  state_q, state_d;
  logic        wen_q, wen_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [63:0] rdata_q, rdata_d;
  logic        flush_seen_q, flush_seen_d;

  logic [3:0]  al_ctrl;
  logic [2:0]  al_addr;
  logic [63:0] al_wdata_lane, al_rdata_ext;
  logic [7:0]  al_wmask;
  logic        al_aligned, al_is_load, al_is_store;
  logic        discard;

  // One aligner serves both directions: incoming op in IDLE, latched op in REQ.
  ysyx_041461_MEM_align u_align (
    .ctrl_i       (al_ctrl),
    .addr_lo_i    (al_addr),
    .wdata_i      (MEM_wdata_in),
    .rdata_i      (bus.mem_rdata),
    .wdata_lane_o (al_wdata_lane),
    .wmask_o      (al_wmask),
    .rdata_ext_o  (al_rdata_ext),
    .aligned_o    (al_aligned),
    .is_load_o    (al_is_load),
    .is_store_o   (al_is_store)
  );

  assign bus.mem_req   = (state_q == ST_REQ);
  assign bus.mem_wen   = wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;
  assign MEM_rdata_out = rdata_q;

  // A flush at any point of the REQ phase kills the result once ack arrives.
  assign discard = flush_seen_q | MEM_flush;

  always_comb begin
    state_d           = state_q;
    wen_d             = wen_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    wmask_d           = wmask_q;
    ctrl_d            = ctrl_q;
    rdata_d           = rdata_q;
    flush_seen_d      = flush_seen_q;
    MEM_valid_out     = 1'b0;
    MEM_exception_out = ysyx_041461_exception_NOP;
    MEM_stall_out     = 1'b0;
    al_ctrl           = MEM_ctrl_in;
    al_addr           = MEM_addr_in[2:0];

    case (state_q)
      ST_IDLE: begin
        if (MEM_flush) begin
          // discarded op: nothing is handed on
        end else if (!MEM_valid_in || MEM_ctrl_in == OP_NOP) begin
          MEM_valid_out = 1'b1;
        end else if (!al_aligned) begin
          MEM_valid_out     = 1'b1;
          MEM_exception_out = al_is_store ? ysyx_041461_exception_SAM
                                          : ysyx_041461_exception_LAM;
        end else begin
          MEM_stall_out = 1'b1;
          state_d       = ST_REQ;
          wen_d         = al_is_store;
          addr_d        = MEM_addr_in;
          wdata_d       = al_wdata_lane;
          wmask_d       = al_is_store ? al_wmask : 8'h00;
          ctrl_d        = MEM_ctrl_in;
          flush_seen_d  = 1'b0;
        end
      end
      ST_REQ: begin
        al_ctrl       = ctrl_q;
        al_addr       = addr_q[2:0];
        MEM_stall_out = 1'b1;
        if (MEM_flush) flush_seen_d = 1'b1;
        if (bus.mem_ack) begin
          if (al_is_load && !discard) rdata_d = al_rdata_ext;
          state_d = discard ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        MEM_valid_out = ~MEM_flush;
        if (MEM_flush || WBreg_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wen_q        <= 1'b0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      wmask_q      <= 8'h00;
      ctrl_q       <= 4'd0;
      rdata_q      <= 64'd0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      ctrl_q       <= ctrl_d;
      rdata_q      <= rdata_d;
      flush_seen_q <= flush_seen_d;
    end
  end
endmodule

// File: tb/tb_ysyx_041461_mem_lsu.sv
// tb/tb_ysyx_041461_mem_lsu.sv - self-checking bench for the MEM-stage LSU
module tb_ysyx_041461_mem_lsu;
  import ysyx_041461_mem_lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        MEM_valid_in;
  logic [3:0]  MEM_ctrl_in;
  logic [63:0] MEM_addr_in;
  logic [63:0] MEM_wdata_in;
  logic        MEM_flush;
  logic        WBreg_enable;
  logic        MEM_valid_out;
  logic [63:0] MEM_rdata_out;
  logic [2:0]  MEM_exception_out;
  logic        MEM_stall_out;

  ysyx_041461_mem_lsu_if bus ();

  ysyx_041461_mem_lsu dut (
    .clk               (clk),
    .rst               (rst),
    .MEM_valid_in      (MEM_valid_in),
    .MEM_ctrl_in       (MEM_ctrl_in),
    .MEM_addr_in       (MEM_addr_in),
    .MEM_wdata_in      (MEM_wdata_in),
    .MEM_flush         (MEM_flush),
    .WBreg_enable      (WBreg_enable),
    .MEM_valid_out     (MEM_valid_out),
    .MEM_rdata_out     (MEM_rdata_out),
    .MEM_exception_out (MEM_exception_out),
    .MEM_stall_out     (MEM_stall_out),
    .bus               (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int req_rises = 0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_req && !prev_req) req_rises++;
    prev_req = bus.mem_req;
  end

  typedef struct {
    logic        valid;
    logic        flush;
    logic [3:0]  ctrl;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] ack_rdata;
    logic        launch;
    logic        exp_valid0;
    logic [2:0]  exp_exc;
    logic        exp_wen;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Misaligned LW is only reported as an exception from IDLE, so this tells IDLE apart.
  task automatic probe_idle(input string name);
    MEM_valid_in = 1'b1; MEM_ctrl_in = OP_LW; MEM_addr_in = 64'h2; MEM_flush = 1'b0;
    #1;
    check(name, {61'd0, MEM_exception_out}, {61'd0, ysyx_041461_exception_LAM});
    MEM_valid_in = 1'b0; MEM_ctrl_in = OP_NOP; MEM_addr_in = 64'h0;
  endtask

  task automatic start_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] w);
    MEM_valid_in = 1'b1; MEM_ctrl_in = c; MEM_addr_in = a; MEM_wdata_in = w; MEM_flush = 1'b0;
    @(negedge clk);
    check("accept_stall", MEM_stall_out, 1'b1);
    tick();
    MEM_valid_in = 1'b0; MEM_ctrl_in = OP_NOP;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    bus.mem_ack = 1'b0; WBreg_enable = 1'b1;
    MEM_flush = v.flush; MEM_valid_in = v.valid; MEM_ctrl_in = v.ctrl;
    MEM_addr_in = v.addr; MEM_wdata_in = v.wdata;
    @(negedge clk);
    check($sformatf("v%0d_stall0", i), MEM_stall_out, v.launch);
    check($sformatf("v%0d_valid0", i), MEM_valid_out, v.exp_valid0);
    if (!v.launch) check($sformatf("v%0d_exc", i), {61'd0, MEM_exception_out}, {61'd0, v.exp_exc});
    tick();
    MEM_valid_in = 1'b0; MEM_flush = 1'b0; MEM_ctrl_in = OP_NOP;
    @(negedge clk);
    check($sformatf("v%0d_req", i), bus.mem_req, v.launch);
    if (v.launch) begin
      check($sformatf("v%0d_wen", i), bus.mem_wen, v.exp_wen);
      check($sformatf("v%0d_addr", i), bus.mem_addr, v.addr);
      check($sformatf("v%0d_req_stall", i), MEM_stall_out, 1'b1);
      if (v.exp_wen) begin
        check($sformatf("v%0d_wmask", i), {56'd0, bus.mem_wmask}, {56'd0, v.exp_wmask});
        check($sformatf("v%0d_wdata", i), bus.mem_wdata, v.exp_wdata);
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = v.ack_rdata;
      tick();
      bus.mem_ack = 1'b0; bus.mem_rdata = 64'd0;
      @(negedge clk);
      check($sformatf("v%0d_done_valid", i), MEM_valid_out, 1'b1);
      check($sformatf("v%0d_done_stall", i), MEM_stall_out, 1'b0);
      check($sformatf("v%0d_done_req", i), bus.mem_req, 1'b0);
      if (!v.exp_wen) check($sformatf("v%0d_rdata", i), MEM_rdata_out, v.exp_rdata);
    end
    tick();
  endtask

  initial begin
    //          valid flush ctrl    addr            wdata        ack_rdata             launch v0 exc                           wen mask   exp_wdata              exp_rdata
    vecs[0]  = '{1, 0, OP_LB,  64'h80000003, 64'h0,        64'h00000000_80000000, 1, 0, ysyx_041461_exception_NOP, 0, 8'h00, 64'h0,                 64'hFFFFFFFF_FFFFFF80};
    vecs[1]  = '{1, 0, OP_SH,  64'h80000006, 64'h1234,     64'h0,                 1, 0, ysyx_041461_exception_NOP, 1, 8'hC0, 64'h1234_0000_0000_0000, 64'h0};
    vecs[2]  = '{1, 0, OP_LW,  64'h80000002, 64'h0,        64'h0,                 0, 1, ysyx_041461_exception_LAM, 0, 8'h00, 64'h0,                 64'h0};
    vecs[3]  = '{1, 0, OP_SD,  64'h80000004, 64'h0,        64'h0,                 0, 1, ysyx_041461_exception_SAM, 0, 8'h00, 64'h0,                 64'h0};
    vecs[4]  = '{1, 0, OP_NOP, 64'h80000000, 64'h0,        64'h0,                 0, 1, ysyx_041461_exception_NOP, 0, 8'h00, 64'h0,                 64'h0};
    vecs[5]  = '{0, 0, OP_LW,  64'h80000000, 64'h0,        64'h0,                 0, 1, ysyx_041461_exception_NOP, 0, 8'h00, 64'h0,                 64'h0};
    vecs[6]  = '{1, 0, OP_LHU, 64'h80000002, 64'h0,        64'h00000000_87650000, 1, 0, ysyx_041461_exception_NOP, 0, 8'h00, 64'h0,                 64'h00000000_00008765};
    vecs[7]  = '{1, 0, OP_LH,  64'h80000002, 64'h0,        64'h00000000_87650000, 1, 0, ysyx_041461_exception_NOP, 0, 8'h00, 64'h0,                 64'hFFFFFFFF_FFFF8765};
    vecs[8]  = '{1, 0, OP_LWU, 64'h80000004, 64'h0,        64'h89ABCDEF_00000000, 1, 0, ysyx_041461_exception_NOP, 0, 8'h00, 64'h0,                 64'h00000000_89ABCDEF};
    vecs[9]  = '{1, 0, OP_LW,  64'h80000004, 64'h0,        64'h89ABCDEF_00000000, 1, 0, ysyx_041461_exception_NOP, 0, 8'h00, 64'h0,                 64'hFFFFFFFF_89ABCDEF};
    vecs[10] = '{1, 0, OP_SW,  64'h80000004, 64'hDEADBEEF, 64'h0,                 1, 0, ysyx_041461_exception_NOP, 1, 8'hF0, 64'hDEADBEEF_00000000, 64'h0};
    vecs[11] = '{1, 0, OP_SB,  64'h80000007, 64'hA5,       64'h0,                 1, 0, ysyx_041461_exception_NOP, 1, 8'h80, 64'hA5000000_00000000, 64'h0};
    vecs[12] = '{1, 0, OP_LBU, 64'h80000000, 64'h0,        64'h11223344_556677F0, 1, 0, ysyx_041461_exception_NOP, 0, 8'h00, 64'h0,                 64'h00000000_000000F0};
    vecs[13] = '{1, 0, OP_LD,  64'h80000008, 64'h0,        64'h01234567_89ABCDEF, 1, 0, ysyx_041461_exception_NOP, 0, 8'h00, 64'h0,                 64'h01234567_89ABCDEF};
    vecs[14] = '{1, 0, OP_SD,  64'h80000010, 64'h00112233_44556677, 64'h0,        1, 0, ysyx_041461_exception_NOP, 1, 8'hFF, 64'h00112233_44556677, 64'h0};
    vecs[15] = '{1, 1, OP_LW,  64'h80000000, 64'h0,        64'h0,                 0, 0, ysyx_041461_exception_NOP, 0, 8'h00, 64'h0,                 64'h0};

    rst = 1'b1; MEM_valid_in = 1'b0; MEM_ctrl_in = OP_NOP; MEM_addr_in = 64'd0;
    MEM_wdata_in = 64'd0; MEM_flush = 1'b0; WBreg_enable = 1'b1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 64'd0;

    @(negedge clk);
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_wen", bus.mem_wen, 1'b0);
    check("rst_addr", bus.mem_addr, 64'd0);
    check("rst_wdata", bus.mem_wdata, 64'd0);
    check("rst_wmask", {56'd0, bus.mem_wmask}, 64'd0);
    check("rst_rdata", MEM_rdata_out, 64'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);
    probe_idle("after_table_idle");

    // Long wait on ack, then WB register holds off for two DONE cycles.
    start_op(OP_LD, 64'h80000020, 64'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("wait%0d_req", k), bus.mem_req, 1'b1);
      check($sformatf("wait%0d_stall", k), MEM_stall_out, 1'b1);
      tick();
    end
    @(negedge clk);
    check("wait_last_req", bus.mem_req, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'hCAFEF00D_12345678; WBreg_enable = 1'b0;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 64'd0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", k), MEM_valid_out, 1'b1);
      check($sformatf("hold%0d_stall", k), MEM_stall_out, 1'b0);
      check($sformatf("hold%0d_rdata", k), MEM_rdata_out, 64'hCAFEF00D_12345678);
      if (k == 1) WBreg_enable = 1'b1;
      tick();
    end
    probe_idle("hold_back_idle");

    // Flush while the request is outstanding: ack three cycles later, result dropped.
    begin
      int rises0;
      rises0 = req_rises;
      start_op(OP_LW, 64'h80000040, 64'h0);
      MEM_flush = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check($sformatf("fl%0d_valid", k), MEM_valid_out, 1'b0);
        check($sformatf("fl%0d_req", k), bus.mem_req, 1'b1);
        if (k == 2) begin bus.mem_ack = 1'b1; bus.mem_rdata = 64'h5555_5555_5555_5555; end
        tick();
        MEM_flush = 1'b0;
      end
      bus.mem_ack = 1'b0;
      @(negedge clk);
      check("fl_req_dropped", bus.mem_req, 1'b0);
      check("fl_stall", MEM_stall_out, 1'b0);
      check("fl_one_txn", req_rises - rises0, 1);
      tick();
      probe_idle("fl_idle");
    end

    // Reset pulse in the middle of a request; a late ack must not revive it.
    start_op(OP_LW, 64'h80000050, 64'h0);
    @(negedge clk);
    check("rr_req_before", bus.mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rr_req_async", bus.mem_req, 1'b0);
    check("rr_addr_async", bus.mem_addr, 64'd0);
    check("rr_rdata_async", MEM_rdata_out, 64'd0);
    tick();
    rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'h7777_7777_7777_7777;
    @(negedge clk);
    check("rr_late_ack_req", bus.mem_req, 1'b0);
    check("rr_late_ack_stall", MEM_stall_out, 1'b0);
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 64'd0;
    @(negedge clk);
    check("rr_late_ack_done", MEM_valid_out, 1'b1);
    check("rr_rdata_kept", MEM_rdata_out, 64'd0);
    tick();
    probe_idle("rr_idle");
    run_vec(100, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
